// File: rtl/aud_pkg.sv
// Shared definitions for the audio playback controller: state encoding,
// default widths and the speed-factor helper.
package aud_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    // Frame counter width: k runs 0..7 at most (F up to 8)
    localparam int K_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_READY = 3'd3,
        ST_PAUSE = 3'd4
    } play_state_e;

    // Speed factor F = 2^speed (1, 2, 4, 8)
    function automatic logic [3:0] speed_factor(input logic [1:0] speed);
        return 4'd1 << speed;
    endfunction

endpackage

// File: rtl/aud_interp.sv
// Combinational linear interpolation between the previous and current
// sample: prev + ((cur - prev) * k) >>> shift, truncated to DATA_W.
module aud_interp
    import aud_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] prev_i,
    input  logic [DATA_W-1:0] cur_i,
    input  logic [K_W-1:0]    k_i,
    input  logic [1:0]        shift_i,
    output logic [DATA_W-1:0] interp_o
);

    localparam int PW = DATA_W + K_W + 2;

    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   diffWide;
    logic signed [PW-1:0]   kWide;
    logic signed [PW-1:0]   product;
    logic signed [PW-1:0]   scaled;

    // Signed difference one bit wider than a sample so it never overflows,
    // then a full-width product and arithmetic shift by log2(F).
    always_comb begin
        diff     = $signed({cur_i[DATA_W-1], cur_i}) - $signed({prev_i[DATA_W-1], prev_i});
        diffWide = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
        kWide    = {{(PW-K_W){1'b0}}, k_i};
        product  = diffWide * kWide;
        scaled   = product >>> shift_i;
        interp_o = DATA_W'($signed({{(PW-DATA_W){prev_i[DATA_W-1]}}, prev_i}) + scaled);
    end

endmodule

// File: rtl/aud_play_ctrl.sv
// Audio playback controller: fetches samples from SRAM once per DAC frame
// (or every F frames in slow mode), optionally interpolates, and hands the
// sample to the player at each left half-frame start.
module aud_play_ctrl
    import aud_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic [1:0]        i_speed,
    input  logic              i_interp,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic              o_sram_req,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic              i_sram_ack,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_player_en,
    output logic [2:0]        o_state,
    output logic              o_done,
    output logic              o_underrun
);

    play_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] dac_q, dac_d;
    logic              underrun_q, underrun_d;
    logic              done_q, done_d;
    logic              endSeen_q, endSeen_d;
    logic              fetched_q, fetched_d;
    logic              pausePend_q, pausePend_d;
    logic [1:0]        speed_q, speed_d;
    logic              fast_q, fast_d;
    logic              interp_q, interp_d;
    logic              lrck_q, lrckDly_q;

    logic              lrckRise, lrckFall;
    logic              needFetch;
    logic              kLast;
    logic [3:0]        speedFactor;
    logic [ADDR_W:0]   nextAddr;
    logic [DATA_W-1:0] interpSample;
    logic [DATA_W-1:0] playSample;

    aud_interp #(
        .DATA_W (DATA_W)
    ) u_interp (
        .prev_i   (prev_q),
        .cur_i    (cur_q),
        .k_i      (k_q),
        .shift_i  (speed_q),
        .interp_o (interpSample)
    );

    // Frame-event helpers: edges of the registered LR clock, fetch decision,
    // slow-mode wrap point and the wide next address used for end detection.
    always_comb begin
        lrckRise    = lrck_q & ~lrckDly_q;
        lrckFall    = ~lrck_q & lrckDly_q;
        needFetch   = ~fetched_q & (i_fast | (k_q == '0));
        speedFactor = speed_factor(speed_q);
        kLast       = ({1'b0, k_q} >= (speedFactor - 4'd1));
        nextAddr    = {1'b0, addr_q} + (fast_q ? {{(ADDR_W-3){1'b0}}, speedFactor}
                                                : {{ADDR_W{1'b0}}, 1'b1});
        playSample  = (~fast_q & interp_q & (speed_q != 2'd0)) ? interpSample : cur_q;
    end

    // Playback FSM next-state and datapath updates; stop overrides every
    // other command, then pause, then start.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        k_d         = k_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        dac_d       = dac_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        endSeen_d   = endSeen_q;
        fetched_d   = fetched_q;
        pausePend_d = pausePend_q;
        speed_d     = speed_q;
        fast_d      = fast_q;
        interp_d    = interp_q;

        if (lrckRise) begin
            speed_d  = i_speed;
            fast_d   = i_fast;
            interp_d = i_interp;
        end

        if ((state_q != ST_IDLE) && i_stop) begin
            state_d     = ST_IDLE;
            addr_d      = '0;
            dac_d       = '0;
            pausePend_d = 1'b0;
            endSeen_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start && !i_pause) begin
                        state_d     = ST_WAIT;
                        addr_d      = '0;
                        k_d         = '0;
                        prev_d      = '0;
                        cur_d       = '0;
                        dac_d       = '0;
                        underrun_d  = 1'b0;
                        endSeen_d   = 1'b0;
                        fetched_d   = 1'b0;
                        pausePend_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_pause) begin
                        state_d = ST_PAUSE;
                        dac_d   = '0;
                    end else if (lrckRise) begin
                        if (endSeen_q) begin
                            state_d   = ST_IDLE;
                            done_d    = 1'b1;
                            addr_d    = '0;
                            dac_d     = '0;
                            endSeen_d = 1'b0;
                        end else if (needFetch) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_READY;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_pause) begin
                        pausePend_d = 1'b1;
                    end
                    if (lrckFall) begin
                        underrun_d = 1'b1;
                    end
                    if (i_sram_ack) begin
                        cur_d     = i_sram_data;
                        prev_d    = cur_q;
                        fetched_d = 1'b1;
                        if (pausePend_q || i_pause) begin
                            state_d     = ST_PAUSE;
                            dac_d       = '0;
                            pausePend_d = 1'b0;
                        end else begin
                            state_d = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (i_pause) begin
                        state_d = ST_PAUSE;
                        dac_d   = '0;
                    end else if (lrckFall) begin
                        state_d   = ST_WAIT;
                        dac_d     = playSample;
                        fetched_d = 1'b0;
                        if (fast_q || kLast) begin
                            k_d = '0;
                            if (nextAddr > {1'b0, i_end_addr}) begin
                                endSeen_d = 1'b1;
                            end else begin
                                addr_d = nextAddr[ADDR_W-1:0];
                            end
                        end else begin
                            k_d = k_q + 3'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_start && !i_pause) begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            k_q         <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            dac_q       <= '0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
            endSeen_q   <= 1'b0;
            fetched_q   <= 1'b0;
            pausePend_q <= 1'b0;
            speed_q     <= 2'd0;
            fast_q      <= 1'b0;
            interp_q    <= 1'b0;
            lrck_q      <= 1'b0;
            lrckDly_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            k_q         <= k_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            dac_q       <= dac_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
            endSeen_q   <= endSeen_d;
            fetched_q   <= fetched_d;
            pausePend_q <= pausePend_d;
            speed_q     <= speed_d;
            fast_q      <= fast_d;
            interp_q    <= interp_d;
            lrck_q      <= i_daclrck;
            lrckDly_q   <= lrck_q;
        end
    end

    // Output decode: the request follows the FETCH state directly so a reset
    // removes it without waiting for a clock edge.
    always_comb begin
        o_state     = state_q;
        o_sram_req  = (state_q == ST_FETCH);
        o_sram_addr = addr_q;
        o_dac_data  = dac_q;
        o_player_en = (state_q == ST_WAIT) || (state_q == ST_FETCH) || (state_q == ST_READY);
        o_done      = done_q;
        o_underrun  = underrun_q;
    end

endmodule

// File: doc/aud_play_ctrl.md
AUD_PLAY_CTRL -- requirements
Module: aud_play_ctrl

Interface
REQ-001 Parameters: ADDR_W, default 20, SRAM word address width; DATA_W, default 16, sample width.
REQ-002 i_bclk  input  1  bit clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_daclrck  input  1  DAC LR clock; low = left half-frame (player shifts data), high = right half-frame.
REQ-005 i_start, i_pause, i_stop  input  1 each  one-cycle command pulses.
REQ-006 i_fast  input  1  speed direction: 1 = fast, 0 = slow.
REQ-007 i_speed  input  2  speed factor F = 2^i_speed (1, 2, 4, 8).
REQ-008 i_interp  input  1  slow mode only: 1 = linear interpolation, 0 = sample hold.
REQ-009 i_end_addr  input  ADDR_W  last valid sample address.
REQ-010 o_sram_req  output  1  read request; o_sram_addr  output  ADDR_W  read address.
REQ-011 i_sram_ack  input  1  read complete; i_sram_data  input  DATA_W  read word, valid with ack.
REQ-012 o_dac_data  output  DATA_W  sample to player; o_player_en  output  1  player enable.
REQ-013 o_state  output  3  FSM state code; o_done  output  1  end-of-track pulse; o_underrun  output  1  sticky fetch-late flag.

Function
REQ-014 States: IDLE=0, WAIT=1, FETCH=2, READY=3, PAUSE=4.
REQ-015 Frame events come from the registered i_daclrck: rise = prepare next sample; fall = frame start.
REQ-016 IDLE: i_start -> WAIT, address = 0, prev = 0, frame counter k = 0.
REQ-017 WAIT: on lrck rise, a fetch is required -> FETCH; otherwise -> READY, with the interpolated value computed in the same cycle.
REQ-018 FETCH: o_sram_req = 1 with o_sram_addr stable until i_sram_ack; on ack, latch data as cur, move old cur to prev, -> READY.
REQ-019 READY: on lrck fall, load o_dac_data with the new sample, advance address/k, -> WAIT.
REQ-020 Underrun: if lrck falls while in FETCH, o_dac_data holds its old value, o_underrun = 1 (cleared only by reset or i_start from IDLE), and the fetch continues.
REQ-021 Fast: fetch every frame; address step = F.
REQ-022 Slow: fetch when k = 0; k counts 0..F-1 and wraps; address step = 1 on wrap.
REQ-023 Slow hold: output = cur.
REQ-024 Slow interp: output = prev + ((cur - prev) * k) >>> i_speed, using 17-bit signed difference and a full-width signed product, truncated to DATA_W.
REQ-025 F = 1 in either mode: plain sequential playback.
REQ-026 End: next address is computed at ADDR_W+1 bits; if it exceeds i_end_addr (including wrap past 2^ADDR_W), the current sample still plays, then at the next lrck rise: o_done = 1 for one cycle, -> IDLE.
REQ-027 Pause: i_pause in WAIT/READY -> PAUSE; in FETCH the pause is deferred until ack, then -> PAUSE with data latched.
REQ-028 In PAUSE: o_player_en = 0, o_dac_data = 0, address/k retained; i_start -> WAIT.
REQ-029 o_player_en = 1 in WAIT, FETCH and READY; 0 in IDLE and PAUSE.
REQ-030 Stop: i_stop in any non-IDLE state -> IDLE, o_sram_req drops next cycle, address = 0, o_dac_data = 0.
REQ-031 Simultaneous commands: stop > pause > start; i_start while playing is ignored.
REQ-032 i_speed, i_fast and i_interp are sampled only at lrck rise, so mid-frame changes take effect on the next frame.

Reset
REQ-033 Async assert: state IDLE, o_sram_req 0, o_sram_addr 0, o_dac_data 0, o_player_en 0, o_done 0, o_underrun 0, prev/cur/k 0.
REQ-034 Reset during FETCH drops o_sram_req immediately, and a late ack is ignored.

Structure
REQ-035 State codes and default widths go in a shared package aud_pkg.
REQ-036 One sub-module, aud_interp, holds the combinational prev/cur/k/shift interpolation.

Verification
REQ-037 Normal play: fast, F=1, end=3, data 0x1000,0x2000,0x3000,0x4000, ack after 2 cycles -> each value on o_dac_data at successive lrck falls, then o_done pulse and IDLE.
REQ-038 Fast F=4, end=10 -> addresses 0,4,8 requested, then done.
REQ-039 Slow F=4 interp, prev 0x0000, cur 0x0100 -> outputs 0x0000,0x0040,0x0080,0x00C0; negative diff 0x0100->0x0000 -> 0x0100,0x00C0,0x0080,0x0040.
REQ-040 Ack withheld past lrck fall -> o_dac_data unchanged, o_underrun = 1, playback resumes after ack.
REQ-041 i_pause during FETCH, then i_start -> no sample lost, player_en 0 while paused; i_stop+i_pause same cycle -> IDLE.
REQ-042 Reset asserted mid-FETCH -> o_sram_req 0 asynchronously, all outputs at their reset values.
